// File: rtl/pci_arbiter.sv
// PCI bus arbiter: round-robin grant over N_MASTERS with grant timeout and optional parking (ARB_PARK_EN).
// Latency: request-to-grant 1 cycle from IDLE/TURN; one all-high turnaround cycle between owners.
// Backpressure: none; GNT is held until FRAME/IRDY show an idle bus, REQ is withdrawn, or the timeout expires.
module pci_arbiter #(
  parameter int N_MASTERS   = 4,
  parameter int GNT_TIMEOUT = 16,
  parameter int PARK_ID     = 0
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [N_MASTERS-1:0]         REQ,
  input  logic                         FRAME,
  input  logic                         IRDY,
  output logic [N_MASTERS-1:0]         GNT,
  output logic [$clog2(N_MASTERS)-1:0] OWNER,
  output logic                         BUS_BUSY,
  output logic                         TIMEOUT
);

  localparam int OW = $clog2(N_MASTERS);
  localparam logic [OW-1:0] PARK_OW  = OW'(PARK_ID);
  localparam logic [OW-1:0] RST_OWN  = OW'(N_MASTERS - 1);
  localparam logic [7:0]    TMO_LAST = 8'(GNT_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, GRANT, BUSY, TURN, PARK} state_t;

  state_t        state;
  logic [7:0]    wait_cnt;
  logic [OW-1:0] winner;
  logic          any_req;

  // Active-low one-hot grant vector for a master index.
  function automatic logic [N_MASTERS-1:0] gnt_for(input logic [OW-1:0] idx);
    logic [N_MASTERS-1:0] v;
    v      = '1;
    v[idx] = 1'b0;
    return v;
  endfunction

  // Round-robin search starting just after the current owner, wrapping around.
  always_comb begin
    int  idx;
    logic found;
    winner  = OWNER;
    found   = 1'b0;
    any_req = ~&REQ;
    for (int i = 1; i <= N_MASTERS; i++) begin
      idx = int'(OWNER) + i;
      if (idx >= N_MASTERS) idx = idx - N_MASTERS;
      if (!found && !REQ[idx]) begin
        winner = OW'(idx);
        found  = 1'b1;
      end
    end
  end

  // Arbitration FSM with registered grant, owner and status outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      GNT      <= '1;
      OWNER    <= RST_OWN;
      BUS_BUSY <= 1'b0;
      TIMEOUT  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      TIMEOUT  <= 1'b0;
      BUS_BUSY <= 1'b0;
      case (state)
        // TURN arbitrates on its exit edge so only one all-high cycle separates grants.
        IDLE, TURN: begin
          if (any_req) begin
            state    <= GRANT;
            GNT      <= gnt_for(winner);
            OWNER    <= winner;
            wait_cnt <= '0;
          end else begin
            GNT   <= '1;
            state <= IDLE;
`ifdef ARB_PARK_EN
            if (state == IDLE) begin
              state <= PARK;
              GNT   <= gnt_for(PARK_OW);
              OWNER <= PARK_OW;
            end
`endif
          end
        end
        GRANT: begin
          if (!FRAME) begin
            state    <= BUSY;
            BUS_BUSY <= 1'b1;
            wait_cnt <= '0;
          end else if (REQ[OWNER]) begin
            state <= TURN;
            GNT   <= '1;
          end else if (wait_cnt == TMO_LAST) begin
            state   <= TURN;
            GNT     <= '1;
            TIMEOUT <= 1'b1;
          end else if (wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        BUSY: begin
          if (FRAME && IRDY) begin
            state <= TURN;
            GNT   <= '1;
          end else begin
            BUS_BUSY <= 1'b1;
          end
        end
        // Parked master keeps its grant; its own request is a direct GRANT.
        PARK: begin
          if (!FRAME) begin
            state    <= BUSY;
            BUS_BUSY <= 1'b1;
            wait_cnt <= '0;
          end else if (!REQ[PARK_OW]) begin
            state    <= GRANT;
            wait_cnt <= '0;
          end else if (any_req) begin
            state <= TURN;
            GNT   <= '1;
          end
        end
        default: begin
          state <= IDLE;
          GNT   <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pci_arbiter.sv
// Directed bench for pci_arbiter (N_MASTERS=4, GNT_TIMEOUT=16, PARK_ID=0).
// Outputs are sampled 1 time unit after each rising edge.
// Park checks run only when ARB_PARK_EN is defined for the build.
module tb_pci_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] REQ;
  logic       FRAME;
  logic       IRDY;
  logic [3:0] GNT;
  logic [1:0] OWNER;
  logic       BUS_BUSY;
  logic       TIMEOUT;

  int vectors     = 0;
  int miscompares = 0;

  pci_arbiter #(.N_MASTERS(4), .GNT_TIMEOUT(16), .PARK_ID(0)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .FRAME(FRAME), .IRDY(IRDY),
    .GNT(GNT), .OWNER(OWNER), .BUS_BUSY(BUS_BUSY), .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [1:0] order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    RST = 1'b1; REQ = 4'b1111; FRAME = 1'b1; IRDY = 1'b1;
    tick(); tick();
    check("rst_gnt",     GNT,      4'b1111);
    check("rst_owner",   OWNER,    2'd3);
    check("rst_busy",    BUS_BUSY, 1'b0);
    check("rst_timeout", TIMEOUT,  1'b0);

    // First grant one cycle after reset release, then FRAME -> BUSY
    REQ = 4'b1110;
    RST = 1'b0;
    tick();
    check("first_gnt",   GNT,   4'b1110);
    check("first_owner", OWNER, 2'd0);
    tick();
    check("grant_hold",  GNT,      4'b1110);
    check("grant_nbusy", BUS_BUSY, 1'b0);
    FRAME = 1'b0;
    tick();
    check("busy_flag",   BUS_BUSY, 1'b1);
    check("busy_gnt",    GNT,      4'b1110);
    FRAME = 1'b1; REQ = 4'b1111;
    tick();
    check("turn_gnt",    GNT,      4'b1111);
    check("turn_nbusy",  BUS_BUSY, 1'b0);
    check("turn_owner",  OWNER,    2'd0);
    tick();
    check("idle_gnt",    GNT,      4'b1111);

    // Round robin with all masters requesting, 3-cycle FRAME each
    RST = 1'b1; tick();
    REQ = 4'b0000; RST = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rr_gnt_%0d", k), GNT, 8'(~(4'b0001 << order[k]) & 4'hF));
      check($sformatf("rr_own_%0d", k), OWNER, order[k]);
      FRAME = 1'b0;
      tick();
      check($sformatf("rr_busy_%0d", k), BUS_BUSY, 1'b1);
      tick(); tick();
      FRAME = 1'b1;
      tick();
      check($sformatf("rr_turn_%0d", k), GNT, 4'b1111);
      tick();
    end
    check("rr_regrant", GNT, 4'b1101);
    REQ = 4'b1111;
    tick();
    check("withdraw_gnt", GNT, 4'b1111);
    tick();

    // Timeout: master 1 never drives FRAME
    REQ = 4'b1101;
    tick();
    check("tmo_gnt0", GNT, 4'b1101);
    for (int i = 1; i < 16; i++) begin
      tick();
      check($sformatf("tmo_gnt%0d", i), GNT, 4'b1101);
      check($sformatf("tmo_np%0d", i), TIMEOUT, 1'b0);
    end
    tick();
    check("tmo_pulse",    TIMEOUT, 1'b1);
    check("tmo_turn_gnt", GNT,     4'b1111);
    tick();
    check("tmo_regrant",  GNT,     4'b1101);
    check("tmo_pulse_end", TIMEOUT, 1'b0);

    // FRAME arrives in the timeout cycle; a non-owner request must not disturb GNT
    REQ = 4'b0101;
    for (int i = 0; i < 15; i++) tick();
    check("nonowner_gnt", GNT, 4'b1101);
    FRAME = 1'b0;
    tick();
    check("late_frame_busy", BUS_BUSY, 1'b1);
    check("late_frame_ntmo", TIMEOUT,  1'b0);
    check("late_frame_gnt",  GNT,      4'b1101);
    RST = 1'b1;
    tick();
    check("rst_busy_gnt",  GNT,      4'b1111);
    check("rst_busy_flag", BUS_BUSY, 1'b0);
    check("rst_busy_own",  OWNER,    2'd3);
    FRAME = 1'b1; REQ = 4'b1111;
    tick();
    RST = 1'b0;

`ifdef ARB_PARK_EN
    tick();
    check("park_gnt",   GNT,   4'b1110);
    check("park_owner", OWNER, 2'd0);
    REQ = 4'b1011;
    tick();
    check("park_turn",  GNT,   4'b1111);
    tick();
    check("park_grant2", GNT,   4'b1011);
    check("park_owner2", OWNER, 2'd2);
`else
    tick();
    check("nopark_gnt0", GNT, 4'b1111);
    tick();
    check("nopark_gnt1", GNT, 4'b1111);
    check("nopark_own",  OWNER, 2'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
